tag_tree_node: RTL and testbench
================================

Name: tag_tree_node

Overview:
- Two-input arbitration node for the tag tree that selects which ready core gets the next packet/job.
- Merges two child (tag, rdy) requests into one (tag, rdy) request toward its parent.
- Routes the parent's ack back to exactly the child whose tag was forwarded.
- Nodes chain into a binary tree, with leaves carrying constant core tags. ENABLE_DELAY inserts a register stage to break long combinational paths.

Parameters:
- TAG_SZ, 5, width of all tag buses.
- ENABLE_DELAY, 0, 0 = purely combinational node; 1 = one-entry registered output stage.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- left_tag  in  TAG_SZ  tag offered by left child.
- left_rdy  in  1  left child has a request.
- left_ack  out  1  left child's request was consumed this cycle.
- right_tag  in  TAG_SZ  tag offered by right child.
- right_rdy  in  1  right child has a request.
- right_ack  out  1  right child's request was consumed this cycle.
- tag  out  TAG_SZ  tag offered to parent.
- rdy  out  1  request valid toward parent.
- ack  in  1  parent consumes the offered tag; ignored when rdy=0.

Behaviour:
- Arbitration (both modes):
  - sel_right = right_rdy & (~left_rdy | prefer_right).
  - grant_valid = left_rdy | right_rdy.
- prefer_right register:
  - Reset value 0.
  - On every consumed child request it is set to the opposite of the side served (left served -> 1, right served -> 0).
  - Unchanged otherwise.
- At most one of left_ack/right_ack is high in any cycle. A child ack is never issued unless that child's rdy is high in the same cycle.
- ENABLE_DELAY=0 (combinational):
  - rdy = grant_valid.
  - tag = sel_right ? right_tag : left_tag. When rdy=0 this is left_tag.
  - left_ack = ack & rdy & ~sel_right.
  - right_ack = ack & rdy & sel_right.
  - Zero latency; a whole combinational tree resolves in one cycle.
- ENABLE_DELAY=1 (registered):
  - Holding register: tag_r (reset 0), rdy_r (reset 0). Outputs tag = tag_r, rdy = rdy_r.
  - load = grant_valid & (~rdy_r | ack).
  - On load: tag_r <= selected child tag; rdy_r <= 1. The selected child's ack is asserted combinationally in that same cycle.
  - If no load and ack & rdy_r: rdy_r <= 0.
  - Otherwise hold; tag_r keeps its last value when rdy_r=0.
  - Latency is 1 cycle from child rdy to parent rdy.
  - Back-to-back throughput is 1 tag/cycle when the parent acks every cycle (drain and refill in the same cycle).
  - The held tag is stable while rdy_r=1 and no ack arrives.
- Reset (both modes):
  - While rst=1: rdy=0, left_ack=0, right_ack=0, prefer_right<=0.
  - In ENABLE_DELAY=1, rdy_r<=0 and tag_r<=0.
  - A tag held in the register when reset asserts is discarded; its child was already acked.
- Simultaneous events:
  - Both children ready: the prefer_right side wins.
  - A child rdy dropping in a cycle without an ack is legal; no state changes.

Optional Feature:
- Macro TREE_NODE_ROUND_ROBIN_EN.
- Defined: round-robin via prefer_right, as described above.
- Undefined: fixed left priority. prefer_right is tied to 0, so sel_right = right_rdy & ~left_rdy. All other behaviour is identical.

Test Plan:
- Combo, left_tag=1/right_tag=2, left_rdy=1, right_rdy=0, ack=1 -> rdy=1, tag=1, left_ack=1, right_ack=0, same cycle.
- Combo, round-robin enabled, both rdy held high with ack=1 for 4 cycles -> tags 1,2,1,2; acks alternate left/right. Without the macro -> tags 1,1,1,1.
- Delay, only right_rdy=1 (tag 2) with ack=0 -> right_ack pulses once. The next cycle rdy=1, tag=2; it holds for 3 cycles with no further child acks. Then ack=1 -> rdy=0 next cycle if no child is ready.
- Delay, both rdy=1, ack=1 continuously -> rdy stays 1 from cycle 2 and the tag changes every cycle. Exactly one child ack per cycle.
- Three-node trees with leaf tags 1..4, driven with random rdys/ack:
  - In the all-combo, all-delay, and mixed (delay left child, combo right and root) builds, every tag acked at the root matches exactly one earlier leaf ack.
  - No leaf is acked while its rdy=0.
- Delay mode, rst=1 while rdy_r=1 -> next cycle rdy=0, tag=0, and no child acks during reset.

Source files
------------

// File: rtl/tag_tree_node.sv
// Two-input tag tree arbitration node: merges two child (tag, rdy) requests toward the parent
// and steers the parent's ack back to the forwarded child. Macro TREE_NODE_ROUND_ROBIN_EN selects round-robin.
module tag_tree_node #(
  parameter int TAG_SZ       = 5,
  parameter int ENABLE_DELAY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_SZ-1:0] left_tag,
  input  logic              left_rdy,
  output logic              left_ack,
  input  logic [TAG_SZ-1:0] right_tag,
  input  logic              right_rdy,
  output logic              right_ack,
  output logic [TAG_SZ-1:0] tag,
  output logic              rdy,
  input  logic              ack
);

  logic              prefer_right;
  logic              grant_valid;
  logic              sel_right;
  logic              take;
  logic [TAG_SZ-1:0] sel_tag;

  assign grant_valid = left_rdy | right_rdy;
  assign sel_right   = right_rdy & (~left_rdy | prefer_right);
  assign sel_tag     = sel_right ? right_tag : left_tag;

  // take marks the cycle in which the selected child's request is consumed
  assign left_ack  = take & ~sel_right;
  assign right_ack = take & sel_right;

`ifdef TREE_NODE_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prefer_right <= 1'b0;
    end else if (take) begin
      prefer_right <= ~sel_right;
    end
  end
`else
  assign prefer_right = 1'b0;
`endif

  if (ENABLE_DELAY != 0) begin : g_reg
    logic [TAG_SZ-1:0] tag_p1;
    logic              vld_p1;
    logic              load;

    // refill whenever the slot is empty or is being drained this very cycle
    assign load = ~rst & grant_valid & (~vld_p1 | ack);

    // stage p1: one-entry holding register toward the parent
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1 <= 1'b0;
        tag_p1 <= '0;
      end else if (load) begin
        vld_p1 <= 1'b1;
        tag_p1 <= sel_tag;
      end else if (ack) begin
        vld_p1 <= 1'b0;
      end
    end

    assign take = load;
    assign tag  = tag_p1;
    assign rdy  = vld_p1 & ~rst;
  end else begin : g_comb
    assign rdy  = grant_valid & ~rst;
    assign tag  = sel_tag;
    assign take = ack & rdy;
  end

endmodule

// File: tb/tb_tag_tree_node.sv
// Bench for tag_tree_node: single combinational and registered nodes against a reference model,
// plus three-node trees (all-combo, all-delay, mixed) checked with a leaf-ack scoreboard.
module tb_tag_tree_node;
  localparam int TW = 5;
`ifdef TREE_NODE_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [TW-1:0] lt = '0, rt = '0;
  logic          lr = 1'b0, rr = 1'b0, ak = 1'b0;
  logic          c_la, c_ra, c_rdy, d_la, d_ra, d_rdy;
  logic [TW-1:0] c_tag, d_tag;

  always #5 clk = ~clk;

  tag_tree_node #(.TAG_SZ(TW), .ENABLE_DELAY(0)) u_comb (
    .clk(clk), .rst(rst),
    .left_tag(lt), .left_rdy(lr), .left_ack(c_la),
    .right_tag(rt), .right_rdy(rr), .right_ack(c_ra),
    .tag(c_tag), .rdy(c_rdy), .ack(ak)
  );

  tag_tree_node #(.TAG_SZ(TW), .ENABLE_DELAY(1)) u_dly (
    .clk(clk), .rst(rst),
    .left_tag(lt), .left_rdy(lr), .left_ack(d_la),
    .right_tag(rt), .right_rdy(rr), .right_ack(d_ra),
    .tag(d_tag), .rdy(d_rdy), .ack(ak)
  );

  // Trees: 0 = all combo, 1 = all delay, 2 = delay left child, combo right child and root
  logic [3:0]    leaf_rdy = 4'b0;
  logic          root_ack = 1'b0;
  logic [3:0]    t_leaf_ack [3];
  logic          t_root_rdy [3];
  logic [TW-1:0] t_root_tag [3];

  for (genvar tr = 0; tr < 3; tr++) begin : g_tree
    localparam int DL = (tr != 0) ? 1 : 0;
    localparam int DR = (tr == 1) ? 1 : 0;
    logic [TW-1:0] l_tag, r_tag, o_tag;
    logic          l_rdy, r_rdy, l_ack, r_ack, o_rdy;
    logic [3:0]    la;

    tag_tree_node #(.TAG_SZ(TW), .ENABLE_DELAY(DL)) u_l (
      .clk(clk), .rst(rst),
      .left_tag(TW'(1)), .left_rdy(leaf_rdy[0]), .left_ack(la[0]),
      .right_tag(TW'(2)), .right_rdy(leaf_rdy[1]), .right_ack(la[1]),
      .tag(l_tag), .rdy(l_rdy), .ack(l_ack)
    );
    tag_tree_node #(.TAG_SZ(TW), .ENABLE_DELAY(DR)) u_r (
      .clk(clk), .rst(rst),
      .left_tag(TW'(3)), .left_rdy(leaf_rdy[2]), .left_ack(la[2]),
      .right_tag(TW'(4)), .right_rdy(leaf_rdy[3]), .right_ack(la[3]),
      .tag(r_tag), .rdy(r_rdy), .ack(r_ack)
    );
    tag_tree_node #(.TAG_SZ(TW), .ENABLE_DELAY(DR)) u_root (
      .clk(clk), .rst(rst),
      .left_tag(l_tag), .left_rdy(l_rdy), .left_ack(l_ack),
      .right_tag(r_tag), .right_rdy(r_rdy), .right_ack(r_ack),
      .tag(o_tag), .rdy(o_rdy), .ack(root_ack)
    );

    assign t_leaf_ack[tr] = la;
    assign t_root_rdy[tr] = o_rdy;
    assign t_root_tag[tr] = o_tag;
  end

  typedef struct {
    logic          rdy;
    logic [TW-1:0] tag;
    logic          la;
    logic          ra;
    bit            tag_vis;
  } exp_t;

  exp_t q_c[$];
  exp_t q_d[$];
  int   checks = 0;
  int   failures = 0;
  bit   tree_on = 1'b0;
  int   pend [3][4];

  // reference state: which side was served last, and the one-entry buffer contents
  bit            c_left_last = 1'b0;
  bit            d_left_last = 1'b0;
  bit            m_full = 1'b0;
  logic [TW-1:0] m_tag = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit pick_right(input bit l, input bit r, input bit left_last);
    if (l && r) return RR && left_last;
    return r;
  endfunction

  task automatic step(input bit s_rst, input bit s_lr, input bit s_rr,
                      input logic [TW-1:0] s_lt, input logic [TW-1:0] s_rt, input bit s_ak);
    exp_t ec, ed;
    bit   w, fill;
    @(posedge clk);
    #1;
    rst = s_rst; lr = s_lr; rr = s_rr; lt = s_lt; rt = s_rt; ak = s_ak;

    w          = pick_right(s_lr, s_rr, c_left_last);
    ec.tag_vis = !s_rst;
    ec.rdy     = !s_rst && (s_lr || s_rr);
    ec.tag     = w ? s_rt : s_lt;
    ec.la      = ec.rdy && s_ak && !w;
    ec.ra      = ec.rdy && s_ak && w;
    if (s_rst) c_left_last = 1'b0;
    else if (ec.la) c_left_last = 1'b1;
    else if (ec.ra) c_left_last = 1'b0;

    ed.tag_vis = 1'b1;
    ed.rdy     = !s_rst && m_full;
    ed.tag     = m_tag;
    ed.la      = 1'b0;
    ed.ra      = 1'b0;
    if (s_rst) begin
      m_full = 1'b0; m_tag = '0; d_left_last = 1'b0;
    end else begin
      fill = (s_lr || s_rr) && (!m_full || s_ak);
      w    = pick_right(s_lr, s_rr, d_left_last);
      if (fill) begin
        m_tag = w ? s_rt : s_lt;
        m_full = 1'b1;
        ed.la = !w;
        ed.ra = w;
        d_left_last = !w;
      end else if (s_ak) begin
        m_full = 1'b0;
      end
    end
    q_c.push_back(ec);
    q_d.push_back(ed);
  endtask

  // single-node monitor: one expectation per driven cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_c.size() > 0) begin
        e = q_c.pop_front();
        chk("comb_rdy", c_rdy, e.rdy);
        if (e.tag_vis) chk("comb_tag", c_tag, e.tag);
        chk("comb_left_ack", c_la, e.la);
        chk("comb_right_ack", c_ra, e.ra);
      end
      if (q_d.size() > 0) begin
        e = q_d.pop_front();
        chk("dly_rdy", d_rdy, e.rdy);
        chk("dly_tag", d_tag, e.tag);
        chk("dly_left_ack", d_la, e.la);
        chk("dly_right_ack", d_ra, e.ra);
      end
    end
  end

  // tree monitor: every root consumption must match an earlier, still-unclaimed leaf ack
  always @(negedge clk) begin
    int  idx;
    bit  found;
    if (tree_on) begin
      for (int tr = 0; tr < 3; tr++) begin
        for (int i = 0; i < 4; i++) begin
          if (t_leaf_ack[tr][i]) begin
            chk($sformatf("tree%0d_leaf%0d_ack_needs_rdy", tr, i), leaf_rdy[i], 1);
            pend[tr][i]++;
          end
        end
        if (t_root_rdy[tr] && root_ack) begin
          idx   = int'(t_root_tag[tr]) - 1;
          found = (idx >= 0) && (idx < 4) && (pend[tr][idx & 3] > 0);
          chk($sformatf("tree%0d_root_tag%0d_matches_leaf_ack", tr, t_root_tag[tr]), found, 1);
          if (found) pend[tr][idx]--;
        end
      end
    end
  end

  initial begin
    int psum;
    for (int tr = 0; tr < 3; tr++)
      for (int i = 0; i < 4; i++) pend[tr][i] = 0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // lone left request, parent acks: same-cycle grant in the combo node
    step(0, 1, 0, 1, 2, 1);
    #2;
    chk("t1_comb_rdy", c_rdy, 1);
    chk("t1_comb_tag", c_tag, 1);
    chk("t1_comb_left_ack", c_la, 1);
    chk("t1_comb_right_ack", c_ra, 0);
    step(0, 0, 0, 1, 2, 1);

    // registered node: single right request, parent stalls, then drains
    step(0, 0, 1, 1, 2, 0);
    #2;
    chk("t3_dly_right_ack_pulse", d_ra, 1);
    chk("t3_dly_left_ack", d_la, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 2, 0);
      #2;
      chk($sformatf("t3_hold%0d_rdy", k), d_rdy, 1);
      chk($sformatf("t3_hold%0d_tag", k), d_tag, 2);
      chk($sformatf("t3_hold%0d_right_ack", k), d_ra, 0);
    end
    step(0, 0, 0, 1, 2, 1);
    step(0, 0, 0, 1, 2, 0);
    #2;
    chk("t3_drained_rdy", d_rdy, 0);

    // both children ready with continuous parent ack
    step(1, 0, 0, 1, 2, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 1, 2, 1);
      #2;
      chk($sformatf("t2_comb_tag%0d", k), c_tag, (RR && (k % 2 == 1)) ? 2 : 1);
      chk($sformatf("t2_comb_left_ack%0d", k), c_la, (RR && (k % 2 == 1)) ? 0 : 1);
      chk($sformatf("t4_dly_one_ack%0d", k), d_la ^ d_ra, 1);
      if (k >= 1) chk($sformatf("t4_dly_rdy%0d", k), d_rdy, 1);
    end

    // reset while the registered node holds a tag
    step(1, 1, 1, 1, 2, 0);
    #2;
    chk("rst_no_child_acks", {c_la, c_ra, d_la, d_ra}, 0);
    chk("rst_dly_rdy", d_rdy, 0);
    step(0, 0, 0, 1, 2, 0);
    #2;
    chk("post_rst_dly_rdy", d_rdy, 0);
    chk("post_rst_dly_tag", d_tag, 0);

    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom),
           TW'($urandom), TW'($urandom), $urandom_range(0, 3) != 0);
    @(posedge clk);
    #1;
    lr = 1'b0; rr = 1'b0; ak = 1'b0;

    // tree phase
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tree_on = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      #1;
      leaf_rdy = 4'($urandom);
      root_ack = $urandom_range(0, 3) != 0;
    end
    @(posedge clk);
    #1;
    leaf_rdy = 4'b0;
    root_ack = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    tree_on = 1'b0;
    for (int tr = 0; tr < 3; tr++) begin
      psum = 0;
      for (int i = 0; i < 4; i++) psum += pend[tr][i];
      chk($sformatf("tree%0d_all_leaf_acks_delivered", tr), psum, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
